// File: rtl/seq_detect_pkg.sv
// Shared constants for the serial pattern detector: reset defaults, match-mode encodings
// and the pattern-length field width helper.
package seq_detect_pkg;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    localparam int         SEQ_DEF_MAX_LEN = 4;
    localparam logic [3:0] SEQ_DEF_PATTERN = 4'b1001;
    localparam int         SEQ_DEF_LEN     = 4;
    localparam logic       SEQ_DEF_OVERLAP = OVL_OFF;

    // Width needed to hold a length in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// Combinational masked compare of the next history window against the pattern over the
// low i_len bits, qualified by enough history (fill) and a non-zero length. Zero latency.
module seq_window_cmp #(
    parameter int MAX_LEN = 4,
    parameter int LEN_W   = 3
) (
    input  logic [MAX_LEN-1:0] i_hist_n,
    input  logic [MAX_LEN-1:0] i_pattern,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [LEN_W-1:0]   i_fill_n,
    output logic               o_match
);

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < i_len) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign o_match = (i_len != '0) &&
                     (i_fill_n >= i_len) &&
                     (((i_hist_n ^ i_pattern) & w_mask) == '0);

endmodule

// File: rtl/seq_pattern_detect.sv
// Serial pattern detector, programmable pattern/length, overlap or non-overlap; one-cycle registered
// match pulse the cycle after the completing bit, no backpressure. SEQ_DETECT_COUNT_EN adds a saturating match counter.
module seq_pattern_detect
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = SEQ_DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
    parameter int                 DEF_LEN     = SEQ_DEF_LEN,
    parameter logic               DEF_OVERLAP = SEQ_DEF_OVERLAP,
`ifdef SEQ_DETECT_COUNT_EN
    parameter int                 COUNT_W     = 16,
`endif
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DETECT_COUNT_EN
    output logic [COUNT_W-1:0] match_count,
`endif
    output logic               seq_seen
);

    localparam logic [LEN_W-1:0] L_MAX_LEN = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_seen;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [LEN_W-1:0]   w_cfg_len;
    logic               w_match;

    // Oldest bit falls off the top; the newest bit enters at bit 0.
    assign w_hist_n  = (r_hist << 1) | MAX_LEN'(inp_bit);
    assign w_fill_n  = (r_fill >= L_MAX_LEN) ? L_MAX_LEN : r_fill + LEN_W'(1);
    assign w_cfg_len = (cfg_len > L_MAX_LEN) ? L_MAX_LEN : cfg_len;

    seq_window_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .i_hist_n  (w_hist_n),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .i_fill_n  (w_fill_n),
        .o_match   (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_overlap <= DEF_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_seen    <= 1'b0;
        end else if (cfg_we) begin
            // A data bit arriving alongside a config write is dropped.
            r_pattern <= cfg_pattern;
            r_len     <= w_cfg_len;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_seen    <= 1'b0;
        end else if (in_valid) begin
            r_seen <= w_match;
            if (w_match && (r_overlap != OVL_ON)) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_n;
                r_fill <= w_fill_n;
            end
        end else begin
            r_seen <= 1'b0;
        end
    end

    assign seq_seen = r_seen;

`ifdef SEQ_DETECT_COUNT_EN
    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || cfg_we) begin
            r_count <= '0;
        end else if (in_valid && w_match && (r_count != '1)) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign match_count = r_count;
`endif

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed bench for seq_pattern_detect: hand-computed pulse sequences per bit, checked with
// immediate assertions; match counter checked when SEQ_DETECT_COUNT_EN is defined (COUNT_W=2).
module tb_seq_pattern_detect;

    logic       clk = 1'b0;
    logic       reset;
    logic       inp_bit;
    logic       in_valid;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       seq_seen;
`ifdef SEQ_DETECT_COUNT_EN
    logic [1:0] match_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_pattern_detect #(
`ifdef SEQ_DETECT_COUNT_EN
        .COUNT_W (2),
`endif
        .MAX_LEN (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inp_bit     (inp_bit),
        .in_valid    (in_valid),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_COUNT_EN
        .match_count (match_count),
`endif
        .seq_seen    (seq_seen)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
`ifdef SEQ_DETECT_COUNT_EN
        check(tag, 32'(match_count), 32'(exp));
`endif
    endtask

    task automatic send(input logic b, input logic exp, input string tag);
        inp_bit  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check(tag, 32'(seq_seen), 32'(exp));
    endtask

    // bits/exp are MSB-first: bit [n-1] is sent first.
    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                          input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], exp[i], $sformatf("%s bit%0d", tag, n - i));
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s idle%0d", tag, i), 32'(seq_seen), 32'd0);
        end
    endtask

    task automatic cfg(input logic [3:0] pat, input logic [2:0] len, input logic ovl,
                       input string tag);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_we      = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check({tag, " cfg seen"}, 32'(seq_seen), 32'd0);
        check_count({tag, " cfg count"}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        inp_bit     = 1'b0;
        in_valid    = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = 4'b0000;
        cfg_len     = 3'd0;
        cfg_overlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset seen", 32'(seq_seen), 32'd0);
        check_count("reset count", 0);

        // 1: defaults (1001, non-overlap); the shared 1 is not reused
        stream(16'b1001001, 16'b0001000, 7, "t1");
        check_count("t1 count", 1);

        // 2: overlap on, same pattern
        cfg(4'b1001, 3'd4, 1'b1, "t2");
        stream(16'b1001001, 16'b0001001, 7, "t2");
        check_count("t2 count", 2);

        // 3: 101 with a set bit above len that must be ignored
        cfg(4'b1101, 3'd3, 1'b1, "t3o");
        stream(16'b10101, 16'b00101, 5, "t3o");
        cfg(4'b1101, 3'd3, 1'b0, "t3n");
        stream(16'b10101, 16'b00100, 5, "t3n");

        // 4: bits separated by 3 idle cycles
        cfg(4'b1001, 3'd4, 1'b0, "t4");
        send(1'b1, 1'b0, "t4 b1"); idle(3, "t4 g1");
        send(1'b0, 1'b0, "t4 b2"); idle(3, "t4 g2");
        send(1'b0, 1'b0, "t4 b3"); idle(3, "t4 g3");
        send(1'b1, 1'b1, "t4 b4"); idle(3, "t4 g4");

        // 5a: reset mid-sequence drops partial history
        stream(16'b100, 16'b000, 3, "t5a pre");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5a reset seen", 32'(seq_seen), 32'd0);
        check_count("t5a reset count", 0);
        stream(16'b1001, 16'b0001, 4, "t5a post");

        // 5b: config write wins over a same-edge data bit
        stream(16'b100, 16'b000, 3, "t5b pre");
        cfg_pattern = 4'b1001;
        cfg_len     = 3'd4;
        cfg_overlap = 1'b0;
        cfg_we      = 1'b1;
        inp_bit     = 1'b1;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check("t5b cfg+valid seen", 32'(seq_seen), 32'd0);
        stream(16'b1001, 16'b0001, 4, "t5b post");

        // 6: len 1, back-to-back pulses, counter saturation
        cfg(4'b0001, 3'd1, 1'b0, "t6");
        stream(16'b11, 16'b11, 2, "t6a");
        check_count("t6 count2", 2);
        stream(16'b111, 16'b111, 3, "t6b");
        check_count("t6 count sat", 3);

        // length above MAX_LEN behaves as MAX_LEN
        cfg(4'b1001, 3'd7, 1'b0, "t6c");
        stream(16'b1001001, 16'b0001000, 7, "t6c");

        // length 0 disables detection
        cfg(4'b0000, 3'd0, 1'b1, "t6d");
        stream(16'b000010, 16'b000000, 6, "t6d");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
